output_argmax: RTL and testbench
================================

OUTPUT_ARGMAX -- requirements
Module: output_argmax

Interface
REQ-001 The block SHALL have parameter bitwidth, default 16, giving the signed element width of the class-score vector.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, with reset synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to classify vec_in.
REQ-005 The block SHALL have port vec_in, input, signed [bitwidth-1:0] x [9:0], the ten fully-connected-layer class scores.
REQ-006 The block SHALL have port busy, output, 1, high while a scan is in progress or done is asserted.
REQ-007 The block SHALL have port done, output, 1, a one-cycle pulse marking valid results.
REQ-008 The block SHALL have port class_idx, output, [3:0], the index (0..9) of the maximum score.
REQ-009 The block SHALL have port max_val, output, signed [bitwidth-1:0], the maximum score.

Function
REQ-010 The block SHALL implement FSM states IDLE, SCAN and DONE.
REQ-011 In IDLE, on the edge where start=1, the block SHALL capture all ten vec_in elements into an internal register bank, set running max to element 0, set running idx to 0 and count to 1, and go to SCAN.
REQ-012 After capture, vec_in SHALL be don't-care; changes to it SHALL NOT affect the result.
REQ-013 In SCAN, on each edge, the block SHALL compare element[count] with the running max as signed values and SHALL update max and idx only if the element is strictly greater, so ties resolve to the lowest index.
REQ-014 In SCAN, count SHALL increment each cycle; after the compare at count=9, the FSM SHALL go to DONE.
REQ-015 In DONE, done=1 for exactly one cycle, class_idx/max_val SHALL present the result, and the next state SHALL be IDLE.
REQ-016 The total latency SHALL be fixed: start accepted at edge k, done high in the cycle following edge k+9, which is 10 cycles later.
REQ-017 class_idx and max_val SHALL hold the last result until the next capture edge, and SHALL NOT show intermediate values mid-scan.
REQ-018 start SHALL be ignored in SCAN and DONE, with no queuing; start held high continuously SHALL cause back-to-back scans at one per 11 cycles.
REQ-019 busy SHALL be 1 in SCAN and DONE and 0 in IDLE.
REQ-020 Comparison SHALL be full signed bitwidth; the most negative value SHALL be handled correctly (all-0x8000 input yields idx 0).

Reset
REQ-021 When rst=1, the block SHALL go to IDLE at the next edge from any state, including mid-SCAN; the partial result SHALL be discarded and no done pulse SHALL be produced.
REQ-022 Reset values SHALL be: busy=0, done=0, class_idx=0, max_val=0, and internal count, idx and score bank all 0.
REQ-023 rst SHALL take priority over start on the same edge.

Configuration
REQ-024 With macro OUTPUT_ARGMAX_TOP2_EN defined, the block SHALL add output ports second_idx [3:0] and second_val signed [bitwidth-1:0], tracking the runner-up in the same scan.
REQ-025 When the runner-up is tracked, a new max SHALL demote the old max to second, and otherwise an element strictly greater than second SHALL replace it.
REQ-026 When the runner-up is tracked, second SHALL be initialised at capture to element 0 with idx 0, and SHALL be reset to 0 with the same hold/update timing as class_idx.
REQ-027 Without OUTPUT_ARGMAX_TOP2_EN, the runner-up ports and logic SHALL be absent and the behaviour SHALL be otherwise identical.

Structure
REQ-028 The shared package lenet_pkg SHALL hold NUM_CLASSES=10, CLASS_IDX_W=4, and the FSM state enum (IDLE, SCAN, DONE).
REQ-029 The block SHALL be implemented as a single module with no sub-module, since the compare is one inline signed comparator.

Verification
REQ-030 The bench SHALL drive vec_in = {0,5,-3,100,7,100,2,0,-1,99} (idx 0..9), pulse start, and check done exactly 10 cycles later with class_idx=3 and max_val=100.
REQ-031 The bench SHALL drive all elements = -32768, and check class_idx=0 and max_val=-32768; with TOP2_EN it SHALL also check second_idx=0.
REQ-032 The bench SHALL drive the maximum 200 at idx 9 with the rest negative, change vec_in to zeros one cycle after start, and check class_idx=9 and max_val=200.
REQ-033 The bench SHALL assert rst at cycle 5 of SCAN, and check no done pulse, all outputs 0, busy=0, and that a new start then completes normally.
REQ-034 The bench SHALL pulse start again at cycles 3 and 10 after the first accept, check both are ignored, and check that start held high yields done pulses exactly 11 cycles apart.
REQ-035 With TOP2_EN, the bench SHALL drive vec_in = {10,50,20,50,0,0,0,0,0,40} and check class_idx=1, max_val=50, second_idx=3 and second_val=50.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared LeNet classifier constants and the argmax FSM state type.
package lenet_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int CLASS_IDX_W = 4;
  localparam logic [CLASS_IDX_W-1:0] LAST_IDX = CLASS_IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } argmax_state_t;

endpackage

// File: rtl/output_argmax.sv
// Sequential argmax over the ten class scores: one signed compare per cycle.
// Optional runner-up tracking is enabled by defining OUTPUT_ARGMAX_TOP2_EN.
module output_argmax
  import lenet_pkg::*;
#(
  parameter int bitwidth = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic signed [bitwidth-1:0]    vec_in [NUM_CLASSES-1:0],
  output logic                          busy,
  output logic                          done,
  output logic        [CLASS_IDX_W-1:0] class_idx,
  output logic signed [bitwidth-1:0]    max_val
`ifdef OUTPUT_ARGMAX_TOP2_EN
  ,
  output logic        [CLASS_IDX_W-1:0] second_idx,
  output logic signed [bitwidth-1:0]    second_val
`endif
);

  argmax_state_t state_reg, state_next;

  logic signed [bitwidth-1:0]    bank_reg [NUM_CLASSES];
  logic        [CLASS_IDX_W-1:0] count_reg;
  logic        [CLASS_IDX_W-1:0] idx_reg, idx_next;
  logic signed [bitwidth-1:0]    max_reg, max_next;
  logic        [CLASS_IDX_W-1:0] class_idx_reg;
  logic signed [bitwidth-1:0]    max_val_reg;
  logic signed [bitwidth-1:0]    elem;
  logic                          take_max;
  logic                          capture;

`ifdef OUTPUT_ARGMAX_TOP2_EN
  logic        [CLASS_IDX_W-1:0] sec_idx_reg, sec_idx_next, second_idx_reg;
  logic signed [bitwidth-1:0]    sec_reg, sec_next, second_val_reg;
`endif

  assign capture = (state_reg == IDLE) && start;

  always_comb begin
    state_next = state_reg;
    elem       = bank_reg[count_reg];
    take_max   = elem > max_reg;
    max_next   = max_reg;
    idx_next   = idx_reg;
    // Strictly-greater update keeps the lowest index on ties.
    if (take_max) begin
      max_next = elem;
      idx_next = count_reg;
    end
`ifdef OUTPUT_ARGMAX_TOP2_EN
    sec_next     = sec_reg;
    sec_idx_next = sec_idx_reg;
    if (take_max) begin
      sec_next     = max_reg;
      sec_idx_next = idx_reg;
    end else if (elem > sec_reg) begin
      sec_next     = elem;
      sec_idx_next = count_reg;
    end
`endif
    case (state_reg)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (count_reg == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      idx_reg       <= '0;
      max_reg       <= '0;
      class_idx_reg <= '0;
      max_val_reg   <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) bank_reg[i] <= '0;
`ifdef OUTPUT_ARGMAX_TOP2_EN
      sec_reg        <= '0;
      sec_idx_reg    <= '0;
      second_val_reg <= '0;
      second_idx_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      if (capture) begin
        for (int i = 0; i < NUM_CLASSES; i++) bank_reg[i] <= vec_in[i];
        max_reg   <= vec_in[0];
        idx_reg   <= '0;
        count_reg <= CLASS_IDX_W'(1);
`ifdef OUTPUT_ARGMAX_TOP2_EN
        sec_reg     <= vec_in[0];
        sec_idx_reg <= '0;
`endif
      end else if (state_reg == SCAN) begin
        max_reg   <= max_next;
        idx_reg   <= idx_next;
        count_reg <= count_reg + CLASS_IDX_W'(1);
`ifdef OUTPUT_ARGMAX_TOP2_EN
        sec_reg     <= sec_next;
        sec_idx_reg <= sec_idx_next;
`endif
        // Outputs only change on the final compare, never mid-scan.
        if (count_reg == LAST_IDX) begin
          class_idx_reg <= idx_next;
          max_val_reg   <= max_next;
`ifdef OUTPUT_ARGMAX_TOP2_EN
          second_idx_reg <= sec_idx_next;
          second_val_reg <= sec_next;
`endif
        end
      end
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign class_idx = class_idx_reg;
  assign max_val   = max_val_reg;
`ifdef OUTPUT_ARGMAX_TOP2_EN
  assign second_idx = second_idx_reg;
  assign second_val = second_val_reg;
`endif

endmodule

// File: tb/tb_output_argmax.sv
// Directed self-checking bench for output_argmax (runner-up checks under OUTPUT_ARGMAX_TOP2_EN).
module tb_output_argmax;

  localparam int W = 16;
  typedef int ivec_t [10];

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic signed [W-1:0] vec_in [9:0];
  logic                busy;
  logic                done;
  logic        [3:0]   class_idx;
  logic signed [W-1:0] max_val;
`ifdef OUTPUT_ARGMAX_TOP2_EN
  logic        [3:0]   second_idx;
  logic signed [W-1:0] second_val;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  output_argmax #(.bitwidth(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vec_in    (vec_in),
    .busy      (busy),
    .done      (done),
    .class_idx (class_idx),
    .max_val   (max_val)
`ifdef OUTPUT_ARGMAX_TOP2_EN
    ,
    .second_idx(second_idx),
    .second_val(second_val)
`endif
  );

  task automatic set_vec(input ivec_t v);
    for (int i = 0; i < 10; i++) vec_in[i] = W'(v[i]);
  endtask

  // Leaves the caller at the first falling edge after the accepting edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    $display("scan: latency=%0d class_idx=%0d max_val=%0d", lat, class_idx, max_val);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    set_vec('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    repeat (3) @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (class_idx !== 4'd0) $display("FAIL reset_class_idx: got %0d want 0", class_idx); else pass_cnt++;
    total_cnt++; if (max_val !== 16'sd0) $display("FAIL reset_max_val: got %0d want 0", max_val); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    set_vec('{0, 5, -3, 100, 7, 100, 2, 0, -1, 99});
    pulse_start();
    total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else pass_cnt++;
    wait_done(lat);
    total_cnt++; if (lat !== 10) $display("FAIL basic_latency: got %0d want 10", lat); else pass_cnt++;
    total_cnt++; if (class_idx !== 4'd3) $display("FAIL basic_class_idx: got %0d want 3", class_idx); else pass_cnt++;
    total_cnt++; if (max_val !== 16'sd100) $display("FAIL basic_max_val: got %0d want 100", max_val); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (class_idx !== 4'd3) $display("FAIL basic_hold_idx: got %0d want 3", class_idx); else pass_cnt++;
  endtask

  task automatic test_most_negative();
    int lat;
    set_vec('{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768});
    pulse_start();
    wait_done(lat);
    total_cnt++; if (class_idx !== 4'd0) $display("FAIL minval_class_idx: got %0d want 0", class_idx); else pass_cnt++;
    total_cnt++; if (max_val !== -32768) $display("FAIL minval_max_val: got %0d want -32768", max_val); else pass_cnt++;
`ifdef OUTPUT_ARGMAX_TOP2_EN
    total_cnt++; if (second_idx !== 4'd0) $display("FAIL minval_second_idx: got %0d want 0", second_idx); else pass_cnt++;
    total_cnt++; if (second_val !== -32768) $display("FAIL minval_second_val: got %0d want -32768", second_val); else pass_cnt++;
`endif
    @(negedge clk);
  endtask

  task automatic test_capture();
    int lat;
    set_vec('{-1, -2, -3, -4, -5, -6, -7, -8, -9, 200});
    pulse_start();
    set_vec('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    repeat (3) @(negedge clk);
    total_cnt++; if (class_idx !== 4'd0) $display("FAIL capture_hold_idx: got %0d want 0", class_idx); else pass_cnt++;
    total_cnt++; if (max_val !== -32768) $display("FAIL capture_hold_val: got %0d want -32768", max_val); else pass_cnt++;
    wait_done(lat);
    total_cnt++; if (lat !== 7) $display("FAIL capture_latency: got %0d want 7", lat); else pass_cnt++;
    total_cnt++; if (class_idx !== 4'd9) $display("FAIL capture_class_idx: got %0d want 9", class_idx); else pass_cnt++;
    total_cnt++; if (max_val !== 16'sd200) $display("FAIL capture_max_val: got %0d want 200", max_val); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    int done_cnt;
    set_vec('{0, 5, -3, 100, 7, 100, 2, 0, -1, 99});
    pulse_start();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (class_idx !== 4'd0) $display("FAIL midrst_class_idx: got %0d want 0", class_idx); else pass_cnt++;
    total_cnt++; if (max_val !== 16'sd0) $display("FAIL midrst_max_val: got %0d want 0", max_val); else pass_cnt++;
`ifdef OUTPUT_ARGMAX_TOP2_EN
    total_cnt++; if (second_idx !== 4'd0) $display("FAIL midrst_second_idx: got %0d want 0", second_idx); else pass_cnt++;
    total_cnt++; if (second_val !== 16'sd0) $display("FAIL midrst_second_val: got %0d want 0", second_val); else pass_cnt++;
`endif
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (done_cnt !== 0) $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt); else pass_cnt++;
    set_vec('{-5, 12, 3, 12, 8, -40, 11, 0, 9, 1});
    pulse_start();
    wait_done(lat);
    total_cnt++; if (lat !== 10) $display("FAIL midrst_restart_latency: got %0d want 10", lat); else pass_cnt++;
    total_cnt++; if (class_idx !== 4'd1) $display("FAIL midrst_restart_idx: got %0d want 1", class_idx); else pass_cnt++;
    total_cnt++; if (max_val !== 16'sd12) $display("FAIL midrst_restart_val: got %0d want 12", max_val); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int done_cnt;
    int done_at;
    logic busy12;
    set_vec('{0, 5, -3, 100, 7, 100, 2, 0, -1, 99});
    pulse_start();
    done_cnt = 0;
    done_at  = -1;
    busy12   = 1'bx;
    for (int i = 1; i <= 14; i++) begin
      start = (i == 3 || i == 10);
      if (i == 3) set_vec('{500, 500, 500, 500, 500, 500, 500, 500, 500, 500});
      if (done === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
      if (i == 12) busy12 = busy;
      @(negedge clk);
    end
    start = 1'b0;
    $display("ignore: done_at=%0d class_idx=%0d max_val=%0d", done_at, class_idx, max_val);
    total_cnt++; if (done_cnt !== 1) $display("FAIL ignore_done_count: got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (done_at !== 10) $display("FAIL ignore_done_at: got %0d want 10", done_at); else pass_cnt++;
    total_cnt++; if (busy12 !== 1'b0) $display("FAIL ignore_no_queue: got busy %b want 0", busy12); else pass_cnt++;
    total_cnt++; if (class_idx !== 4'd3) $display("FAIL ignore_class_idx: got %0d want 3", class_idx); else pass_cnt++;
    total_cnt++; if (max_val !== 16'sd100) $display("FAIL ignore_max_val: got %0d want 100", max_val); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int first_at;
    int second_at;
    set_vec('{3, 1, 4, 1, 5, 9, 2, 6, 5, 3});
    @(negedge clk);
    start     = 1'b1;
    first_at  = -1;
    second_at = -1;
    for (int i = 0; i <= 40; i++) begin
      if (done === 1'b1) begin
        if (first_at < 0) first_at = i;
        else if (second_at < 0) second_at = i;
      end
      @(negedge clk);
    end
    start = 1'b0;
    $display("b2b: first_done=%0d second_done=%0d class_idx=%0d max_val=%0d", first_at, second_at, class_idx, max_val);
    total_cnt++; if (first_at !== 10) $display("FAIL b2b_first: got %0d want 10", first_at); else pass_cnt++;
    total_cnt++; if (second_at - first_at !== 11) $display("FAIL b2b_spacing: got %0d want 11", second_at - first_at); else pass_cnt++;
    total_cnt++; if (class_idx !== 4'd5) $display("FAIL b2b_class_idx: got %0d want 5", class_idx); else pass_cnt++;
    total_cnt++; if (max_val !== 16'sd9) $display("FAIL b2b_max_val: got %0d want 9", max_val); else pass_cnt++;
    repeat (15) @(negedge clk);
  endtask

`ifdef OUTPUT_ARGMAX_TOP2_EN
  task automatic test_top2();
    int lat;
    set_vec('{10, 50, 20, 50, 0, 0, 0, 0, 0, 40});
    pulse_start();
    wait_done(lat);
    $display("top2: second_idx=%0d second_val=%0d", second_idx, second_val);
    total_cnt++; if (class_idx !== 4'd1) $display("FAIL top2_class_idx: got %0d want 1", class_idx); else pass_cnt++;
    total_cnt++; if (max_val !== 16'sd50) $display("FAIL top2_max_val: got %0d want 50", max_val); else pass_cnt++;
    total_cnt++; if (second_idx !== 4'd3) $display("FAIL top2_second_idx: got %0d want 3", second_idx); else pass_cnt++;
    total_cnt++; if (second_val !== 16'sd50) $display("FAIL top2_second_val: got %0d want 50", second_val); else pass_cnt++;
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_most_negative();
    test_capture();
    test_reset_mid_scan();
    test_ignore_start();
    test_back_to_back();
`ifdef OUTPUT_ARGMAX_TOP2_EN
    test_top2();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
